// File: rtl/cmos_packer_pkg.sv
// cmos_packer_pkg: shared FSM states, RGB565 field widths and packing helper.
package cmos_packer_pkg;
  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;
  localparam int R_BITS = 5;
  localparam int G_BITS = 6;
  localparam int B_BITS = 5;
  function automatic logic [15:0] rgb565(input logic [R_BITS-1:0] r, input logic [G_BITS-1:0] g,
                                         input logic [B_BITS-1:0] b);
    return {r, g, b};
  endfunction
endpackage

// File: rtl/cmos_bayer_rgb_packer_fifo.sv
// packer_fifo: synchronous FIFO with full/empty flags; push while full succeeds only alongside a pop.
module packer_fifo #(
  parameter int W = 33,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wr, rd;
  logic do_push, do_pop;
  assign empty = wr == rd;
  assign full = (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = empty ? '0 : mem[rd[AW-1:0]];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr <= '0;
      rd <= '0;
    end else begin
      if (do_push) wr <= wr + 1'b1;
      if (do_pop) rd <= rd + 1'b1;
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr[AW-1:0]] <= din;
endmodule

// File: rtl/cmos_bayer_rgb_packer.sv
// cmos_bayer_rgb_packer: GRBG Bayer -> RGB565 demosaic, two pixels per 32-bit word, FIFO'd stream.
// CMOS_PACKER_TESTPAT_EN adds test_mode, replacing each rgb with {row[7:0], col[7:0]}.
module cmos_bayer_rgb_packer
  import cmos_packer_pkg::*;
#(
  parameter int PIX_W = 12,
  parameter int MAX_WIDTH = 640,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             frame_valid,
  input  logic             line_valid,
  input  logic [PIX_W-1:0] pixel,
`ifdef CMOS_PACKER_TESTPAT_EN
  input  logic             test_mode,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_sof,
  output logic             frame_done,
  output logic             overflow,
  input  logic             clear_overflow
);
  localparam int CW = $clog2(MAX_WIDTH + 1);
`ifdef CMOS_PACKER_TESTPAT_EN
  localparam int RW = 8;
`else
  localparam int RW = 1;
`endif
  state_t state, state_n;
  logic fv_q, lv_q, fv_rise, fv_fall, lv_fall, cap_entry, pix_ok;
  logic [CW-1:0] col, col_cur;
  logic [RW-1:0] row;
  logic [PIX_W-1:0] lb [MAX_WIDTH];
  logic [PIX_W-1:0] g1, r;
  logic [B_BITS-1:0] b5;
  logic [15:0] lo, rgb, rgb_demo;
  logic pend_valid, pend_sof, sof_pend, full, empty, pop, drop;
  logic [31:0] pend_word;
  assign fv_rise = frame_valid && !fv_q;
  assign fv_fall = !frame_valid && fv_q;
  assign lv_fall = !line_valid && lv_q;
  assign col_cur = lv_q ? col : '0;
  assign pix_ok = state == CAPTURE && frame_valid && line_valid && col_cur < MAX_WIDTH;
  assign cap_entry = state == ARMED && state_n == CAPTURE;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = enable && !frame_valid ? ARMED : IDLE;
      ARMED:   state_n = !enable ? IDLE : fv_rise ? CAPTURE : ARMED;
      CAPTURE: state_n = fv_fall ? DONE : CAPTURE;
      default: state_n = enable ? ARMED : IDLE;
    endcase
  end
  // Odd row, odd col: the even row above supplies G1 at col-1 and R at col.
  assign g1 = lb[{col_cur[CW-1:1], 1'b0}];
  assign r = lb[col_cur];
  assign rgb_demo = rgb565(R_BITS'(r >> (PIX_W - R_BITS)),
                           G_BITS'(({1'b0, g1} + {1'b0, pixel}) >> (PIX_W + 1 - G_BITS)), b5);
`ifdef CMOS_PACKER_TESTPAT_EN
  assign rgb = test_mode ? {8'(row), 8'(col_cur)} : rgb_demo;
`else
  assign rgb = rgb_demo;
`endif
  assign frame_done = state == DONE;
  assign pop = out_valid && out_ready;
  assign drop = pend_valid && full && !pop;
  assign out_valid = !empty;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      fv_q <= 1'b0;
      lv_q <= 1'b0;
      col <= '0;
      row <= '0;
      b5 <= '0;
      lo <= '0;
      pend_valid <= 1'b0;
      pend_word <= '0;
      pend_sof <= 1'b0;
      sof_pend <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_n;
      fv_q <= frame_valid;
      lv_q <= line_valid;
      col <= frame_valid && line_valid && col_cur < MAX_WIDTH ? col_cur + 1'b1 : col_cur;
      if (cap_entry) row <= '0;
      else if (state == CAPTURE && lv_fall) row <= row + 1'b1;
      if (pix_ok && row[0] && !col_cur[0]) b5 <= B_BITS'(pixel >> (PIX_W - B_BITS));
      if (pix_ok && row[0] && col_cur[1:0] == 2'b01) lo <= rgb;
      pend_valid <= pix_ok && row[0] && col_cur[1:0] == 2'b11;
      if (pix_ok && row[0] && col_cur[1:0] == 2'b11) begin
        pend_word <= {rgb, lo};
        pend_sof <= sof_pend;
      end
      if (cap_entry) sof_pend <= 1'b1;
      else if (pix_ok && row[0] && col_cur[1:0] == 2'b11) sof_pend <= 1'b0;
      overflow <= drop || (overflow && !clear_overflow);
    end
  always_ff @(posedge clk)
    if (pix_ok && !row[0]) lb[col_cur] <= pixel;
  packer_fifo #(.W(33), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(pend_valid),
    .din({pend_sof, pend_word}),
    .pop(pop),
    .dout({out_sof, out_data}),
    .full(full),
    .empty(empty)
  );
endmodule

// File: tb/tb_cmos_bayer_rgb_packer.sv
// tb_cmos_bayer_rgb_packer: table-driven frames plus corner sequences, scoreboarded output words.
module tb_cmos_bayer_rgb_packer;
  logic clk = 0, reset = 1, enable = 0, frame_valid = 0, line_valid = 0;
  logic [11:0] pixel = 0;
  logic out_valid, out_ready = 1, out_sof, frame_done, overflow, clear_overflow = 0;
  logic [31:0] out_data;
`ifdef CMOS_PACKER_TESTPAT_EN
  logic test_mode = 0;
`endif
  typedef struct {
    logic [31:0] data;
    logic        sof;
    int          cyc;
  } sb_t;
  typedef struct {
    logic [11:0] p [2][4];
    logic [31:0] word;
  } vec_t;
  sb_t sb[$];
  vec_t tbl[5];
  logic [11:0] pm [4][32];
  int n_vec = 0, n_err = 0, cyc = 0;

  cmos_bayer_rgb_packer dut (
    .clk(clk), .reset(reset), .enable(enable), .frame_valid(frame_valid),
    .line_valid(line_valid), .pixel(pixel),
`ifdef CMOS_PACKER_TESTPAT_EN
    .test_mode(test_mode),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sof(out_sof),
    .frame_done(frame_done), .overflow(overflow), .clear_overflow(clear_overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [15:0] mrgb(input logic [11:0] r, input logic [11:0] g1,
                                       input logic [11:0] g2, input logic [11:0] b);
    logic [12:0] s;
    s = {1'b0, g1} + {1'b0, g2};
    return {r[11:7], s[12:7], b[11:7]};
  endfunction

  always @(negedge clk)
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_word: got %h sof %b, expected no word", out_data, out_sof);
      end else begin
        sb_t e;
        e = sb.pop_front();
        chk("word", {out_data}, e.data);
        chk("sof", {31'b0, out_sof}, {31'b0, e.sof});
        if (e.cyc >= 0) chk("latency", cyc, e.cyc);
      end
    end

  task automatic frame(input int w, input int rows, input bit cap, input int max_push,
                       input bit use_fixed, input logic [31:0] fixed, input bit lat, input bit en_mid);
    int pushed;
    sb_t e;
    pushed = 0;
    @(posedge clk); #1 frame_valid = 1;
    if (en_mid) begin @(posedge clk); #1 enable = 1; end
    repeat (2) @(posedge clk);
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < w; c++) begin
        @(posedge clk); #1 line_valid = 1; pixel = pm[r][c];
        if (cap && r % 2 == 1 && c % 4 == 3 && pushed < max_push) begin
          e.data = use_fixed ? fixed :
                   {mrgb(pm[r-1][c], pm[r-1][c-1], pm[r][c], pm[r][c-1]),
                    mrgb(pm[r-1][c-2], pm[r-1][c-3], pm[r][c-2], pm[r][c-3])};
          e.sof = pushed == 0;
          e.cyc = lat ? cyc + 2 : -1;
          sb.push_back(e);
          pushed++;
        end
      end
      @(posedge clk); #1 line_valid = 0; pixel = 0;
      repeat (3) @(posedge clk);
    end
    @(posedge clk); #1 frame_valid = 0;
    @(posedge clk);
    @(negedge clk) chk("frame_done_pulse", {31'b0, frame_done}, {31'b0, cap});
    @(negedge clk) chk("frame_done_end", {31'b0, frame_done}, 32'd0);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clk);
    chk(name, sb.size(), 0);
  endtask

  task automatic load_vec(input int i);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 4; c++) pm[r][c] = tbl[i].p[r][c];
  endtask

  initial begin
    tbl[0].p = '{'{12'h800, 12'hFFF, 12'h800, 12'h000}, '{12'h000, 12'h800, 12'hFFF, 12'h800}};
    tbl[0].word = 32'h041F_FC00;
    tbl[1].p = '{'{12'h000, 12'h000, 12'h000, 12'h000}, '{12'h000, 12'h000, 12'h000, 12'h000}};
    tbl[1].word = 32'h0000_0000;
    tbl[2].p = '{'{12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF}, '{12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF}};
    tbl[2].word = 32'hFFFF_FFFF;
    tbl[3].p = '{'{12'h080, 12'h100, 12'h180, 12'h200}, '{12'h300, 12'h380, 12'h400, 12'h480}};
    tbl[3].word = 32'h2188_1106;
    tbl[4].p = '{'{12'h07F, 12'hF80, 12'h0FF, 12'h07F}, '{12'hF80, 12'h07F, 12'h07F, 12'h001}};
    tbl[4].word = 32'h0040_F83F;

    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_sof", {31'b0, out_sof}, 32'd0);
    chk("rst_frame_done", {31'b0, frame_done}, 32'd0);
    chk("rst_overflow", {31'b0, overflow}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 0; enable = 1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 5; i++) begin
      load_vec(i);
      frame(4, 2, 1, 1, 1, tbl[i].word, 1, 0);
      drain("table_drain");
    end

    // Arming: enable rises mid-frame, that frame is skipped, the next is captured.
    @(posedge clk); #1 enable = 0;
    repeat (3) @(posedge clk);
    load_vec(3);
    frame(4, 2, 0, 0, 0, 0, 0, 1);
    frame(4, 2, 1, 1, 1, tbl[3].word, 1, 0);
    drain("arming_drain");

    // Overflow: 8 words into a 4-entry FIFO with no consumer.
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 32; c++) pm[r][c] = 12'($urandom);
    out_ready = 0;
    frame(32, 2, 1, 4, 0, 0, 0, 0);
    chk("ovf_set", {31'b0, overflow}, 32'd1);
    chk("ovf_fifo_valid", {31'b0, out_valid}, 32'd1);
    @(posedge clk); #1 clear_overflow = 1;
    @(posedge clk); #1 clear_overflow = 0;
    @(negedge clk) chk("ovf_clear", {31'b0, overflow}, 32'd0);
    out_ready = 1;
    drain("ovf_drain");

    // Odd tail: width 6, four rows, one word per odd row.
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 6; c++) pm[r][c] = 12'($urandom);
    frame(6, 4, 1, 8, 0, 0, 1, 0);
    drain("tail_drain");

    // Reset mid-capture with a word waiting in the FIFO.
    load_vec(4);
    out_ready = 0;
    frame(4, 2, 1, 1, 1, tbl[4].word, 0, 0);
    @(negedge clk) chk("pre_rst_valid", {31'b0, out_valid}, 32'd1);
    @(posedge clk); #1 frame_valid = 1;
    repeat (3) @(posedge clk);
    #1 line_valid = 1; pixel = 12'h123;
    @(posedge clk); #1 reset = 1;
    #1;
    chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_out_data", out_data, 32'd0);
    chk("mid_rst_out_sof", {31'b0, out_sof}, 32'd0);
    chk("mid_rst_overflow", {31'b0, overflow}, 32'd0);
    sb.delete();
    @(posedge clk); #1 reset = 0; line_valid = 0; out_ready = 1;
    load_vec(0);
    frame(4, 2, 0, 0, 0, 0, 0, 0);
    frame(4, 2, 1, 1, 1, tbl[0].word, 1, 0);
    drain("post_rst_drain");

`ifdef CMOS_PACKER_TESTPAT_EN
    test_mode = 1;
    frame(4, 2, 1, 1, 1, 32'h0103_0101, 1, 0);
    drain("testpat_drain");
    test_mode = 0;
`endif

    repeat (5) @(negedge clk);
    chk("final_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
